// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_feeder
// Purpose : Byte FIFO plus write sequencer that drains queued bytes into a
//           UART transmitter over a Tx_DATA / Tx_WR / Tx_BUSY handshake.
// Revision: 1.0
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  feed_en,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic [DATA_W-1:0]     Tx_DATA,
    output logic                  Tx_WR,
    input  logic                  Tx_BUSY,
    output logic [15:0]           sent_cnt
);

    localparam int                 DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] level_q, level_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                overflow_q, overflow_d;
    state_t              state_q, state_d;
    logic                tx_wr_q, tx_wr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [15:0]         sent_cnt_q, sent_cnt_d;

    logic                push_ok;
    logic                pop;
    logic                sent_inc;

    // Acceptance is judged on the registered full flag, so a simultaneous
    // pop never frees a slot for the same-cycle push.
    assign push_ok = push && !full_q;

    // ------------------------------------------------------------------
    // Sequencer: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tx_wr_d  = tx_wr_q;
        pop      = 1'b0;
        sent_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (feed_en && !empty_q && !Tx_BUSY) begin
                    pop     = 1'b1;
                    tx_wr_d = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // feed_en is ignored here: a popped byte is always delivered.
                if (Tx_BUSY) begin
                    tx_wr_d  = 1'b0;
                    sent_inc = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!Tx_BUSY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_wr_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        // Pointer difference modulo 2**(DEPTH_LOG2+1) is the occupancy.
        level_d    = wr_ptr_d - rd_ptr_d;
        full_d     = (level_d == LEVEL_MAX);
        empty_d    = (level_d == '0);
        overflow_d = overflow_q | (push & full_q);
        tx_data_d  = pop ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : tx_data_q;
        sent_cnt_d = sent_inc ? sent_cnt_q + 16'd1 : sent_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= '0;
            sent_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            tx_wr_q    <= tx_wr_d;
            tx_data_q  <= tx_data_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign Tx_DATA  = tx_data_q;
    assign Tx_WR    = tx_wr_q;
    assign sent_cnt = sent_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_feeder
// Purpose : Directed self-checking bench for uart_tx_feeder.
// Revision: 1.0
// ============================================================================
module tb_uart_tx_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        feed_en;
    logic        push;
    logic [7:0]  push_data;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR;
    logic        Tx_BUSY;
    logic [15:0] sent_cnt;

    logic        man_busy   = 1'b0;
    logic        model_en   = 1'b0;
    logic        model_busy = 1'b0;
    int          busy_len   = 10;
    int          busy_cnt   = 0;

    int          checks   = 0;
    int          failures = 0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic        wr_prev = 1'b0;
    int          rise_while_busy = 0;

    assign Tx_BUSY = model_en ? model_busy : man_busy;

    uart_tx_feeder #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .feed_en   (feed_en),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .Tx_DATA   (Tx_DATA),
        .Tx_WR     (Tx_WR),
        .Tx_BUSY   (Tx_BUSY),
        .sent_cnt  (sent_cnt)
    );

    always #5 clk = ~clk;

    // Capture every Tx_WR rising edge; busy is sampled before the model reacts.
    always @(posedge clk) begin
        #1;
        if (Tx_WR && !wr_prev) begin
            got_q.push_back(Tx_DATA);
            if (Tx_BUSY) rise_while_busy++;
        end
        wr_prev = Tx_WR;
    end

    // Transmitter model: goes busy for busy_len cycles after seeing Tx_WR.
    always @(posedge clk) begin
        #2;
        if (!model_en) begin
            model_busy = 1'b0;
            busy_cnt   = 0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end else if (Tx_WR && !model_busy) begin
            model_busy = 1'b1;
            busy_cnt   = busy_len;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int bad;
        int pushed;

        reset     = 1'b0;
        feed_en   = 1'b0;
        push      = 1'b0;
        push_data = 8'h00;
        #12;
        chk("rst_wr",    32'(Tx_WR), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf",   32'(overflow), 32'd0);
        chk("rst_data",  32'(Tx_DATA), 32'd0);
        chk("rst_sent",  32'(sent_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single byte, manual busy handshake
        feed_en   = 1'b1;
        push      = 1'b1;
        push_data = 8'h94;
        tick();
        push = 1'b0;
        chk("t2_level1", 32'(level), 32'd1);
        chk("t2_wr_lat", 32'(Tx_WR), 32'd0);
        tick();
        chk("t2_wr",     32'(Tx_WR), 32'd1);
        chk("t2_data",   32'(Tx_DATA), 32'h94);
        chk("t2_level0", 32'(level), 32'd0);
        tick(3);
        chk("t2_hold_wr",   32'(Tx_WR), 32'd1);
        chk("t2_hold_data", 32'(Tx_DATA), 32'h94);
        man_busy = 1'b1;
        tick();
        chk("t2_wr_drop", 32'(Tx_WR), 32'd0);
        chk("t2_sent",    32'(sent_cnt), 32'd1);
        tick(2);
        chk("t2_wait_wr", 32'(Tx_WR), 32'd0);
        man_busy = 1'b0;
        tick(2);
        chk("t2_idle_wr", 32'(Tx_WR), 32'd0);
        chk("t2_data_kept", 32'(Tx_DATA), 32'h94);

        // Asynchronous reset while armed with a byte still queued
        push      = 1'b1;
        push_data = 8'h3C;
        tick();
        push_data = 8'h77;
        tick();
        push = 1'b0;
        chk("t1_armed", 32'(Tx_WR), 32'd1);
        chk("t1_lvl",   32'(level), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t1_wr",    32'(Tx_WR), 32'd0);
        chk("t1_level", 32'(level), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_sent",  32'(sent_cnt), 32'd0);
        chk("t1_data",  32'(Tx_DATA), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Three back-to-back bytes with a 10-cycle busy transmitter
        got_q.delete();
        rise_while_busy = 0;
        busy_len = 10;
        model_en = 1'b1;
        push = 1'b1;
        push_data = 8'hA1; tick();
        push_data = 8'h55; tick();
        push_data = 8'h0F; tick();
        push = 1'b0;
        tick(80);
        chk("t3_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("t3_b0", 32'(got_q[0]), 32'hA1);
            chk("t3_b1", 32'(got_q[1]), 32'h55);
            chk("t3_b2", 32'(got_q[2]), 32'h0F);
        end
        chk("t3_sent", 32'(sent_cnt), 32'd3);
        chk("t3_no_wr_busy", 32'(rise_while_busy), 32'd0);

        // Fill past capacity with feeding disabled, then drain
        feed_en = 1'b0;
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            push_data = 8'(8'h10 + i);
            tick();
        end
        push = 1'b0;
        chk("t4_full",  32'(full), 32'd1);
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_ovf0",  32'(overflow), 32'd0);
        push = 1'b1;
        push_data = 8'hEE;
        tick();
        push = 1'b0;
        chk("t4_ovf1",   32'(overflow), 32'd1);
        chk("t4_level2", 32'(level), 32'd16);
        feed_en = 1'b1;
        tick(300);
        chk("t4_count", 32'(got_q.size()), 32'd16);
        bad = 0;
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            if (got_q[i] !== 8'(8'h10 + i)) bad++;
        end
        chk("t4_order", 32'(bad), 32'd0);
        chk("t4_sent",  32'(sent_cnt), 32'd19);
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Push while full coinciding with a pop
        model_en = 1'b0;
        feed_en  = 1'b0;
        reset    = 1'b0;
        #2;
        chk("t5_ovf_clr", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1;
            push_data = 8'(8'hC0 + i);
            tick();
        end
        chk("t5_full", 32'(full), 32'd1);
        got_q.delete();
        feed_en   = 1'b1;
        push      = 1'b1;
        push_data = 8'hEE;
        tick();
        push = 1'b0;
        chk("t5_ovf",   32'(overflow), 32'd1);
        chk("t5_level", 32'(level), 32'd15);
        chk("t5_wr",    32'(Tx_WR), 32'd1);
        chk("t5_data",  32'(Tx_DATA), 32'hC0);
        model_en = 1'b1;
        tick(300);
        chk("t5_count", 32'(got_q.size()), 32'd16);
        if (got_q.size() == 16) chk("t5_last", 32'(got_q[15]), 32'hCF);
        chk("t5_sent", 32'(sent_cnt), 32'd16);

        // Streaming across pointer wrap with a scoreboard
        busy_len = 1;
        got_q.delete();
        exp_q.delete();
        pushed = 0;
        for (int cyc = 0; cyc < 3000 && got_q.size() < 40; cyc++) begin
            if (pushed < 40 && !full && (cyc % 3) != 1) begin
                push      = 1'b1;
                push_data = 8'(pushed * 37 + 5);
                exp_q.push_back(push_data);
                pushed++;
            end else begin
                push = 1'b0;
            end
            tick();
        end
        push = 1'b0;
        tick(5);
        chk("t6_count", 32'(got_q.size()), 32'd40);
        bad = 0;
        for (int i = 0; i < 40 && i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) bad++;
        end
        chk("t6_order", 32'(bad), 32'd0);
        chk("t6_sent",  32'(sent_cnt), 32'd56);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_no_wr_busy", 32'(rise_while_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
